// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL start-up calibration blocks.
package adpll_pkg;

  localparam int THRESH_W = 5;
  localparam logic [THRESH_W-1:0] THRESH_RST = 5'd16;

  // Calibration controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DECIDE  = 3'd4,
    ST_DONE    = 3'd5
  } cal_state_e;

  // Period meter phases
  typedef enum logic [1:0] {
    MP_IDLE    = 2'd0,
    MP_ALIGN   = 2'd1,
    MP_MEASURE = 2'd2
  } meter_phase_e;

  // One successive-approximation step: drop the trial bit if rejected, then
  // arm the next lower bit as the new trial.
  function automatic logic [THRESH_W-1:0] sar_next(
    input logic [THRESH_W-1:0] thresh,
    input logic [2:0]          idx,
    input logic                keep
  );
    logic [THRESH_W-1:0] r;
    r = thresh;
    if (!keep) begin
      r[idx] = 1'b0;
    end else begin
      r[idx] = thresh[idx];
    end
    if (idx != 3'd0) begin
      r[idx - 3'd1] = 1'b1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/dco_period_meter.sv
// Measures MEAS_EDGES DCO periods in clk cycles after aligning to a DCO
// rising edge. Reports timeout/saturation as a saturated measurement.
module dco_period_meter
  import adpll_pkg::*;
#(
  parameter int MEAS_EDGES = 8,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dco_clk_in,
  output logic             aligned,
  output logic             done,
  output logic             sat,
  output logic [CNT_W-1:0] meas_cnt
);

  localparam int EDGE_W = (MEAS_EDGES > 1) ? $clog2(MEAS_EDGES + 1) : 1;
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(MEAS_EDGES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  meter_phase_e      phase_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [EDGE_W-1:0] edge_r;
  logic              dco_q_r;
  logic              sat_r;
  logic [CNT_W-1:0]  meas_r;
  logic              rise_s;
  logic              full_s;

  assign rise_s   = dco_clk_in & ~dco_q_r;
  assign full_s   = (cnt_r == CNT_MAX);
  assign sat      = sat_r;
  assign meas_cnt = meas_r;

  // Handshake flags back to the controller for the current cycle
  always_comb begin
    aligned = 1'b0;
    done    = 1'b0;
    case (phase_r)
      MP_ALIGN: begin
        if (rise_s) begin
          aligned = 1'b1;
        end else begin
          done = full_s;
        end
      end
      MP_MEASURE: begin
        if (full_s) begin
          done = 1'b1;
        end else begin
          done = rise_s && (edge_r == EDGE_LAST);
        end
      end
      default: begin
        aligned = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  // Edge detect, align/measure counting and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r <= MP_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      edge_r  <= {EDGE_W{1'b0}};
      dco_q_r <= 1'b0;
      sat_r   <= 1'b0;
      meas_r  <= {CNT_W{1'b0}};
    end else begin
      dco_q_r <= dco_clk_in;
      case (phase_r)
        MP_IDLE: begin
          if (start) begin
            phase_r <= MP_ALIGN;
            cnt_r   <= {CNT_W{1'b0}};
            edge_r  <= {EDGE_W{1'b0}};
            sat_r   <= 1'b0;
          end
        end
        MP_ALIGN: begin
          if (rise_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            edge_r  <= {EDGE_W{1'b0}};
            phase_r <= MP_MEASURE;
          end else if (full_s) begin
            sat_r   <= 1'b1;
            meas_r  <= CNT_MAX;
            phase_r <= MP_IDLE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        MP_MEASURE: begin
          if (full_s) begin
            sat_r   <= 1'b1;
            meas_r  <= CNT_MAX;
            phase_r <= MP_IDLE;
          end else if (rise_s && (edge_r == EDGE_LAST)) begin
            meas_r  <= cnt_r + 1'b1;
            phase_r <= MP_IDLE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
            if (rise_s) begin
              edge_r <= edge_r + 1'b1;
            end
          end
        end
        default: phase_r <= MP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dco_cal_ctrl.sv
// Start-up calibration controller: 5-step SAR search of the DCO threshold
// against a target clk count, then hands the DCO to the loop filter.
module dco_cal_ctrl
  import adpll_pkg::*;
#(
  parameter int MEAS_EDGES = 8,
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cal_start,
  input  logic [CNT_W-1:0]    target_cnt,
  input  logic                dco_clk_in,
  output logic [THRESH_W-1:0] thresh_val,
  output logic                loop_en,
  output logic                cal_busy,
  output logic                cal_done,
  output logic                cal_err,
  output logic [CNT_W-1:0]    meas_cnt
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  cal_state_e          state_r, state_nx;
  logic [SET_W-1:0]    settle_r, settle_nx;
  logic [2:0]          idx_r, idx_nx;
  logic [CNT_W-1:0]    target_r, target_nx;
  logic [THRESH_W-1:0] thresh_r, thresh_nx;
  logic                loop_en_r, loop_en_nx;
  logic                busy_r, busy_nx;
  logic                done_r, done_nx;
  logic                err_r, err_nx;
  logic                meas_start_s;
  logic                keep_s;
  logic                m_aligned_s;
  logic                m_done_s;
  logic                m_sat_s;
  logic [CNT_W-1:0]    m_cnt_s;

  dco_period_meter #(
    .MEAS_EDGES (MEAS_EDGES),
    .CNT_W      (CNT_W)
  ) u_meter (
    .clk        (clk),
    .reset      (reset),
    .start      (meas_start_s),
    .dco_clk_in (dco_clk_in),
    .aligned    (m_aligned_s),
    .done       (m_done_s),
    .sat        (m_sat_s),
    .meas_cnt   (m_cnt_s)
  );

  assign thresh_val = thresh_r;
  assign loop_en    = loop_en_r;
  assign cal_busy   = busy_r;
  assign cal_done   = done_r;
  assign cal_err    = err_r;
  assign meas_cnt   = m_cnt_s;

  // Next-state and next-output logic of the search sequencer
  always_comb begin
    state_nx     = state_r;
    settle_nx    = settle_r;
    idx_nx       = idx_r;
    target_nx    = target_r;
    thresh_nx    = thresh_r;
    loop_en_nx   = loop_en_r;
    busy_nx      = busy_r;
    done_nx      = done_r;
    err_nx       = err_r;
    meas_start_s = 1'b0;
    keep_s       = (m_cnt_s <= target_r) && !m_sat_s;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (cal_start) begin
          target_nx  = target_cnt;
          thresh_nx  = THRESH_RST;
          idx_nx     = 3'd4;
          loop_en_nx = 1'b0;
          done_nx    = 1'b0;
          err_nx     = 1'b0;
          busy_nx    = 1'b1;
          settle_nx  = {SET_W{1'b0}};
          state_nx   = ST_SETTLE;
        end else begin
          state_nx = state_r;
        end
      end
      ST_SETTLE: begin
        if (settle_r == SETTLE_LAST) begin
          settle_nx    = {SET_W{1'b0}};
          meas_start_s = 1'b1;
          state_nx     = ST_ALIGN;
        end else begin
          settle_nx = settle_r + 1'b1;
        end
      end
      ST_ALIGN: begin
        if (m_done_s) begin
          state_nx = ST_DECIDE;
        end else if (m_aligned_s) begin
          state_nx = ST_MEASURE;
        end else begin
          state_nx = ST_ALIGN;
        end
      end
      ST_MEASURE: begin
        if (m_done_s) begin
          state_nx = ST_DECIDE;
        end else begin
          state_nx = ST_MEASURE;
        end
      end
      ST_DECIDE: begin
        thresh_nx = sar_next(thresh_r, idx_r, keep_s);
        err_nx    = err_r | m_sat_s;
        if (idx_r != 3'd0) begin
          idx_nx    = idx_r - 3'd1;
          settle_nx = {SET_W{1'b0}};
          state_nx  = ST_SETTLE;
        end else begin
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
          loop_en_nx = 1'b1;
          state_nx   = ST_DONE;
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        loop_en_nx = 1'b0;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      settle_r  <= {SET_W{1'b0}};
      idx_r     <= 3'd4;
      target_r  <= {CNT_W{1'b0}};
      thresh_r  <= THRESH_RST;
      loop_en_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      settle_r  <= settle_nx;
      idx_r     <= idx_nx;
      target_r  <= target_nx;
      thresh_r  <= thresh_nx;
      loop_en_r <= loop_en_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      err_r     <= err_nx;
    end
  end

endmodule

// File: tb/tb_dco_cal_ctrl.sv
// Scoreboard bench for dco_cal_ctrl driven by a behavioural counter DCO.
module tb_dco_cal_ctrl;

  logic        clk;
  logic        reset;
  logic        cal_start;
  logic [11:0] target_cnt;
  logic        dco_clk_in;
  logic [4:0]  thresh_val;
  logic        loop_en;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_err;
  logic [11:0] meas_cnt;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    int thr;
    int err;
  } fin_t;

  int   meas_q[$];
  fin_t fin_q[$];

  // behavioural DCO state
  int   dco_cnt    = 0;
  logic dco_out    = 1'b0;
  int   dco_offset = 0;
  bit   dco_hold   = 1'b0;

  dco_cal_ctrl #(.MEAS_EDGES(8), .CNT_W(12), .SETTLE_CYC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cal_start  (cal_start),
    .target_cnt (target_cnt),
    .dco_clk_in (dco_clk_in),
    .thresh_val (thresh_val),
    .loop_en    (loop_en),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_err    (cal_err),
    .meas_cnt   (meas_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter DCO: half period of thresh_val+1 cycles, counting from the offset
  always @(negedge clk) begin
    if (dco_cnt >= int'(thresh_val) + dco_offset) begin
      dco_cnt <= dco_offset;
      dco_out <= ~dco_out;
    end else begin
      dco_cnt <= dco_cnt + 1;
    end
  end

  assign dco_clk_in = dco_hold ? 1'b0 : dco_out;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: step results and final results popped from the scoreboard
  logic       busy_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic [4:0] thr_prev  = 5'd16;
  always @(negedge clk) begin
    if (!reset) begin
      if ((busy_prev && cal_busy && (thresh_val != thr_prev)) || (cal_done && !done_prev)) begin
        if (meas_q.size() == 0) begin
          chk("meas_unexpected", int'(meas_cnt), -1);
        end else begin
          chk("meas_cnt", int'(meas_cnt), meas_q.pop_front());
        end
      end
      if (cal_done && !done_prev) begin
        if (fin_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          fin_t f;
          f = fin_q.pop_front();
          chk("final_thresh", int'(thresh_val), f.thr);
          chk("final_err", int'(cal_err), f.err);
          chk("final_loop_en", int'(loop_en), 1);
          chk("final_busy", int'(cal_busy), 0);
        end
      end
    end
    busy_prev <= cal_busy;
    done_prev <= cal_done;
    thr_prev  <= thresh_val;
  end

  task automatic push_run(input int m0, input int m1, input int m2, input int m3,
                          input int m4, input int thr, input int err);
    fin_t f;
    meas_q.push_back(m0);
    meas_q.push_back(m1);
    meas_q.push_back(m2);
    meas_q.push_back(m3);
    meas_q.push_back(m4);
    f.thr = thr;
    f.err = err;
    fin_q.push_back(f);
  endtask

  task automatic pulse_start(input int tgt);
    @(negedge clk);
    target_cnt = 12'(tgt);
    cal_start  = 1'b1;
    @(negedge clk);
    cal_start  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (!cal_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cal_done) chk(nm, 0, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_thresh"}, int'(thresh_val), 16);
    chk({tag, "_loop_en"}, int'(loop_en), 0);
    chk({tag, "_busy"}, int'(cal_busy), 0);
    chk({tag, "_done"}, int'(cal_done), 0);
    chk({tag, "_err"}, int'(cal_err), 0);
    chk({tag, "_meas"}, int'(meas_cnt), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    cal_start  = 1'b0;
    target_cnt = 12'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // nominal search
    push_run(272, 144, 208, 176, 192, 11, 0);
    pulse_start(192);
    chk("start_busy", int'(cal_busy), 1);
    chk("start_thresh", int'(thresh_val), 16);
    wait_done("done_t192", 6000);

    // lower bound: every trial bit rejected
    push_run(272, 144, 80, 48, 32, 0, 0);
    pulse_start(0);
    wait_done("done_t0", 6000);

    // upper bound: every trial bit kept
    push_run(272, 400, 464, 496, 512, 31, 0);
    pulse_start(4095);
    wait_done("done_t4095", 6000);

    // DCO stuck low: every step times out
    dco_hold = 1'b1;
    push_run(4095, 4095, 4095, 4095, 4095, 0, 1);
    pulse_start(192);
    wait_done("done_timeout", 30000);
    dco_hold = 1'b0;

    // start pulse in MEASURE of step 2 must be ignored
    push_run(272, 144, 208, 176, 192, 11, 0);
    pulse_start(192);
    n = 0;
    while (thresh_val != 5'd8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (thresh_val != 5'd8) chk("reach_step2", int'(thresh_val), 8);
    repeat (30) @(negedge clk);
    pulse_start(0);
    wait_done("done_ignored_start", 6000);

    // restart from DONE drops loop_en on the next cycle
    push_run(272, 144, 208, 176, 192, 11, 0);
    pulse_start(192);
    chk("restart_loop_en", int'(loop_en), 0);
    chk("restart_busy", int'(cal_busy), 1);
    chk("restart_done", int'(cal_done), 0);
    chk("restart_thresh", int'(thresh_val), 16);
    wait_done("done_restart", 6000);

    // asynchronous reset in the middle of a measurement
    push_run(272, 144, 208, 176, 192, 11, 0);
    pulse_start(192);
    repeat (60) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    meas_q.delete();
    fin_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    push_run(272, 144, 208, 176, 192, 11, 0);
    pulse_start(192);
    wait_done("done_after_reset", 6000);

    // DCO offset does not change the period
    dco_offset = 5;
    push_run(272, 144, 208, 176, 192, 11, 0);
    pulse_start(192);
    wait_done("done_offset5", 6000);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", meas_q.size() + fin_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
